// File: rtl/direct_mapped_cache_if.sv
// Word-wide request/response bus used on both the CPU side and the memory side of the cache.
// The master drives read/write/address/wdata; the slave answers with rdata and a one-cycle ready pulse.
interface direct_mapped_cache_if #(
  parameter int WIDTH = 16
);
  logic             read;
  logic             write;
  logic [WIDTH-1:0] address;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;
  logic             ready;

  modport master (output read, write, address, wdata, input rdata, ready);
  modport slave  (input read, write, address, wdata, output rdata, ready);
endinterface

// File: rtl/direct_mapped_cache.sv
// Direct-mapped write-through, no-write-allocate cache; read hit answers 2 edges after the request.
// Each request is held until cpu.ready; misses and writes stall on the memory ready pulse.
module direct_mapped_cache #(
  parameter int WORD_SIZE      = 16,
  parameter int NUM_LINES      = 4,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  direct_mapped_cache_if.slave     cpu,
  direct_mapped_cache_if.master    mem,
  output logic [WORD_SIZE-1:0]     hit_count,
  output logic [WORD_SIZE-1:0]     miss_count
);
  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = WORD_SIZE - IDX_W - OFF_W;
  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS_PER_LINE - 1);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] index;
    logic [OFF_W-1:0] offset;
  } addr_t;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE_MEM, RESPOND} state_t;

  state_t               state;
  addr_t                cpu_a;
  addr_t                req_q;
  logic [OFF_W-1:0]     wcnt;
  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [WORD_SIZE-1:0] data_q [NUM_LINES][WORDS_PER_LINE];

  logic req_vld;
  logic req_hit;
  logic wr_hit_we;
  logic refill_we;

  function automatic logic [WORD_SIZE-1:0] sat_inc(input logic [WORD_SIZE-1:0] v);
    return (&v) ? v : v + WORD_SIZE'(1);
  endfunction

  assign cpu_a     = cpu.address;
  assign req_hit   = valid_q[cpu_a.index] && (tag_q[cpu_a.index] == cpu_a.tag);
  // The cycle cpu.ready is high still carries the old request, so it is skipped.
  assign req_vld   = (state == IDLE) && !cpu.ready && (cpu.read || cpu.write);
  assign wr_hit_we = req_vld && cpu.write && req_hit;
  assign refill_we = (state == REFILL) && mem.ready;

  // Tag and data storage carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (wr_hit_we) begin
      data_q[cpu_a.index][cpu_a.offset] <= cpu.wdata;
    end
    if (refill_we) begin
      data_q[req_q.index][wcnt] <= mem.rdata;
      if (wcnt == LAST_WORD) begin
        tag_q[req_q.index] <= req_q.tag;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      valid_q     <= '0;
      req_q       <= '0;
      wcnt        <= '0;
      cpu.ready   <= 1'b0;
      cpu.rdata   <= '0;
      mem.read    <= 1'b0;
      mem.write   <= 1'b0;
      mem.address <= '0;
      mem.wdata   <= '0;
      hit_count   <= '0;
      miss_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          cpu.ready <= 1'b0;
          if (req_vld) begin
            req_q <= cpu_a;
            if (cpu.write) begin
              if (req_hit) hit_count  <= sat_inc(hit_count);
              else         miss_count <= sat_inc(miss_count);
              mem.write   <= 1'b1;
              mem.address <= cpu.address;
              mem.wdata   <= cpu.wdata;
              state       <= WRITE_MEM;
            end else if (req_hit) begin
              cpu.rdata <= data_q[cpu_a.index][cpu_a.offset];
              hit_count <= sat_inc(hit_count);
              state     <= RESPOND;
            end else begin
              valid_q[cpu_a.index] <= 1'b0;
              wcnt                 <= '0;
              miss_count           <= sat_inc(miss_count);
              mem.read             <= 1'b1;
              mem.address          <= {cpu_a.tag, cpu_a.index, {OFF_W{1'b0}}};
              state                <= REFILL;
            end
          end
        end

        REFILL: begin
          if (mem.ready) begin
            if (wcnt == LAST_WORD) begin
              valid_q[req_q.index] <= 1'b1;
              mem.read             <= 1'b0;
              // The last word is only now arriving, so it cannot come from the array.
              cpu.rdata <= (req_q.offset == LAST_WORD) ? mem.rdata
                                                       : data_q[req_q.index][req_q.offset];
              state     <= RESPOND;
            end else begin
              wcnt        <= wcnt + OFF_W'(1);
              mem.address <= {req_q.tag, req_q.index, wcnt + OFF_W'(1)};
            end
          end
        end

        WRITE_MEM: begin
          if (mem.ready) begin
            mem.write <= 1'b0;
            state     <= RESPOND;
          end
        end

        RESPOND: begin
          cpu.ready <= 1'b1;
          state     <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_direct_mapped_cache.sv
// Randomized scoreboard bench for direct_mapped_cache with a line-presence reference model.
// Expected CPU responses and memory transactions are queued at issue time and popped by monitors.
module tb_direct_mapped_cache;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  always #5 clk = ~clk;

  direct_mapped_cache_if #(.WIDTH(16)) cpu ();
  direct_mapped_cache_if #(.WIDTH(16)) mem ();

  direct_mapped_cache dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cpu        (cpu),
    .mem        (mem),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
  } mtx_t;

  typedef struct {
    logic        rd;
    logic [15:0] rdata;
    logic [15:0] hits;
    logic [15:0] misses;
  } rsp_t;

  mtx_t mq[$];
  rsp_t rq[$];

  logic [15:0] mem_arr [0:65535];
  logic [15:0] ref_mem [0:65535];

  // Reference model: which tag each line holds, and the performance counts.
  bit          m_valid [4];
  logic [11:0] m_tag   [4];
  int          m_hits;
  int          m_misses;

  int total = 0;
  int bad   = 0;
  int acks  = 0;
  int lat_min = 0;
  int lat_max = 2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [15:0] addr,
                       input logic [15:0] wdata);
    int   idx;
    bit   hit;
    int   n;
    rsp_t r;
    idx = int'(addr[3:2]);
    hit = m_valid[idx] && (m_tag[idx] == addr[15:4]);
    if (hit) begin
      if (m_hits < 65535) m_hits++;
    end else begin
      if (m_misses < 65535) m_misses++;
    end
    if (wr) begin
      ref_mem[addr] = wdata;
      mq.push_back('{1'b1, addr, wdata});
    end else if (!hit) begin
      m_valid[idx] = 1'b1;
      m_tag[idx]   = addr[15:4];
      for (int k = 0; k < 4; k++) mq.push_back('{1'b0, {addr[15:2], 2'(k)}, 16'h0});
    end
    r.rd     = !wr;
    r.rdata  = ref_mem[addr];
    r.hits   = 16'(m_hits);
    r.misses = 16'(m_misses);
    rq.push_back(r);

    @(posedge clk); #1;
    cpu.read    = rd;
    cpu.write   = wr;
    cpu.address = addr;
    cpu.wdata   = wdata;
    n = 0;
    forever begin
      @(posedge clk); #1;
      n++;
      if (cpu.ready) break;
      if (n > 200) begin
        total++;
        bad++;
        $display("FAIL timeout waiting for cpu_ready addr=%h", addr);
        break;
      end
    end
    cpu.read  = 1'b0;
    cpu.write = 1'b0;
    if (!wr && hit) check("read_hit_latency", 32'(n), 32'd2);
  endtask

  // Memory model: answers each request after a random delay with a one-cycle ready pulse.
  initial begin
    int   dly;
    mtx_t t;
    dly       = -1;
    mem.ready = 1'b0;
    mem.rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem.ready = 1'b0;
      if (!reset_n) begin
        dly = -1;
        continue;
      end
      if (mem.read || mem.write) begin
        if (dly < 0) dly = $urandom_range(lat_max, lat_min);
        if (dly == 0) begin
          acks++;
          dly = -1;
          if (mq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected mem access addr=%h rd=%b wr=%b",
                     mem.address, mem.read, mem.write);
          end else begin
            t = mq.pop_front();
            check("mem_is_write", 32'(mem.write), 32'(t.wr));
            check("mem_address", 32'(mem.address), 32'(t.addr));
            if (t.wr) check("mem_wdata", 32'(mem.wdata), 32'(t.wdata));
          end
          if (mem.write) mem_arr[mem.address] = mem.wdata;
          else           mem.rdata = mem_arr[mem.address];
          mem.ready = 1'b1;
        end else begin
          dly--;
        end
      end else begin
        dly = -1;
      end
    end
  end

  // CPU-side monitor.
  initial begin
    rsp_t r;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        check("mem_rd_wr_exclusive", 32'(mem.read && mem.write), 32'd0);
        if (cpu.ready) begin
          if (rq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected cpu_ready rdata=%h", cpu.rdata);
          end else begin
            r = rq.pop_front();
            if (r.rd) check("cpu_rdata", 32'(cpu.rdata), 32'(r.rdata));
            check("hit_count", 32'(hit_count), 32'(r.hits));
            check("miss_count", 32'(miss_count), 32'(r.misses));
          end
        end
      end
    end
  end

  initial begin
    int          a0;
    int          n;
    logic [15:0] a;
    logic [15:0] d;
    int          op;

    for (int i = 0; i < 65536; i++) begin
      mem_arr[i] = 16'(i * 40503) ^ 16'h5A5A;
    end
    mem_arr[16'h0023] = 16'h6000;
    mem_arr[16'h0063] = 16'hf8c6;
    for (int i = 0; i < 65536; i++) ref_mem[i] = mem_arr[i];
    model_reset();

    cpu.read    = 1'b0;
    cpu.write   = 1'b0;
    cpu.address = '0;
    cpu.wdata   = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_cpu_ready", 32'(cpu.ready), 32'd0);
    check("reset_cpu_rdata", 32'(cpu.rdata), 32'd0);
    check("reset_mem_read", 32'(mem.read), 32'd0);
    check("reset_mem_write", 32'(mem.write), 32'd0);
    check("reset_mem_address", 32'(mem.address), 32'd0);
    check("reset_hit_count", 32'(hit_count), 32'd0);
    check("reset_miss_count", 32'(miss_count), 32'd0);
    reset_n = 1'b1;

    issue(1'b1, 1'b0, 16'h0023, 16'h0);
    issue(1'b1, 1'b0, 16'h0021, 16'h0);
    issue(1'b1, 1'b0, 16'h0063, 16'h0);
    issue(1'b1, 1'b0, 16'h0023, 16'h0);
    issue(1'b1, 1'b0, 16'h0063, 16'h0);
    issue(1'b0, 1'b1, 16'h0061, 16'hBEEF);
    check("mem_0061_written", 32'(mem_arr[16'h0061]), 32'h0000BEEF);
    issue(1'b1, 1'b0, 16'h0061, 16'h0);
    issue(1'b0, 1'b1, 16'h00F0, 16'h1234);
    issue(1'b1, 1'b0, 16'h00F0, 16'h0);
    issue(1'b1, 1'b1, 16'h0062, 16'h7777);
    issue(1'b1, 1'b0, 16'h0062, 16'h0);

    // Reset in the middle of a refill, while the second word is outstanding.
    lat_min = 3;
    lat_max = 4;
    for (int k = 0; k < 4; k++) mq.push_back('{1'b0, 16'h0040 + 16'(k), 16'h0});
    @(posedge clk); #1;
    a0          = acks;
    cpu.read    = 1'b1;
    cpu.address = 16'h0043;
    n = 0;
    while (acks == a0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("refill_first_word_seen", 32'(acks - a0), 32'd1);
    @(negedge clk);
    @(negedge clk);
    check("refill_mem_read_high", 32'(mem.read), 32'd1);
    check("refill_second_address", 32'(mem.address), 32'h0041);
    reset_n = 1'b0;
    #1;
    check("abort_mem_read", 32'(mem.read), 32'd0);
    check("abort_hit_count", 32'(hit_count), 32'd0);
    check("abort_miss_count", 32'(miss_count), 32'd0);
    check("abort_cpu_ready", 32'(cpu.ready), 32'd0);
    cpu.read = 1'b0;
    mq.delete();
    rq.delete();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    lat_min = 0;
    lat_max = 2;
    issue(1'b1, 1'b0, 16'h0041, 16'h0);
    issue(1'b1, 1'b0, 16'h0042, 16'h0);

    for (int i = 0; i < 400; i++) begin
      a  = 16'($urandom_range(0, 63));
      if ($urandom_range(0, 15) == 0) a = 16'($urandom);
      d  = 16'($urandom);
      op = $urandom_range(0, 9);
      if (op < 6)      issue(1'b1, 1'b0, a, d);
      else if (op < 9) issue(1'b0, 1'b1, a, d);
      else             issue(1'b1, 1'b1, a, d);
    end

    @(negedge clk);
    #1;
    check("responses_drained", 32'(rq.size()), 32'd0);
    check("mem_ops_drained", 32'(mq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
